// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer: FSM state encodings and default
// qualification parameters.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE_LOW  = 2'b00,
        ST_WAIT_HIGH = 2'b01,
        ST_IDLE_HIGH = 2'b11,
        ST_WAIT_LOW  = 2'b10
    } dbnc_state_e;

    localparam int DEFAULT_STABLE_CYCLES = 4;
    localparam int DEFAULT_CNT_WIDTH     = 3;

    // A candidate level is being qualified only in the two WAIT states.
    function automatic logic is_wait_state(input dbnc_state_e st);
        logic wait_s;
        case (st)
            ST_WAIT_HIGH: wait_s = 1'b1;
            ST_WAIT_LOW:  wait_s = 1'b1;
            default:      wait_s = 1'b0;
        endcase
        return wait_s;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit; shared by every
// asynchronous input in the codebase.
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync1_q;
    logic q_q;

    // Back-to-back flops with nothing in between to give the first stage a full cycle to resolve.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            q_q     <= 1'b0;
        end else begin
            sync1_q <= d;
            q_q     <= sync1_q;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/input_debouncer.sv
// Debounces one raw asynchronous input: synchronizes it, qualifies level changes
// over STABLE_CYCLES consecutive samples, and emits registered rise/fall pulses.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    if ((STABLE_CYCLES < 2) || (STABLE_CYCLES > (2 ** CNT_WIDTH))) begin : g_param_check
        $error("input_debouncer: STABLE_CYCLES out of range for CNT_WIDTH");
    end

    logic                 s_sync;
    dbnc_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 dout_q, dout_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;

    sync2 u_sync2 (
        .clock (clock),
        .reset (reset),
        .d     (din),
        .q     (s_sync)
    );

    // Next-state logic: any disagreeing sample in a WAIT state drops back to IDLE with the count cleared.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_IDLE_LOW: begin
                if (s_sync) begin
                    state_d = ST_WAIT_HIGH;
                    count_d = CNT_ONE;
                end else begin
                    count_d = CNT_ZERO;
                end
            end
            ST_WAIT_HIGH: begin
                if (!s_sync) begin
                    state_d = ST_IDLE_LOW;
                    count_d = CNT_ZERO;
                end else if (count_q == CNT_LAST) begin
                    state_d = ST_IDLE_HIGH;
                    count_d = CNT_ZERO;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            ST_IDLE_HIGH: begin
                if (!s_sync) begin
                    state_d = ST_WAIT_LOW;
                    count_d = CNT_ONE;
                end else begin
                    count_d = CNT_ZERO;
                end
            end
            ST_WAIT_LOW: begin
                if (s_sync) begin
                    state_d = ST_IDLE_HIGH;
                    count_d = CNT_ZERO;
                end else if (count_q == CNT_LAST) begin
                    state_d = ST_IDLE_LOW;
                    count_d = CNT_ZERO;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE_LOW;
                count_d = CNT_ZERO;
                dout_d  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE_LOW;
            count_q <= CNT_ZERO;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = is_wait_state(state_q);

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Conditions one raw, asynchronous, bouncy input (switch, button or external strobe) into a clean, synchronous level that drives the D input of the team's asynchronous set/reset D flip-flop. The raw input passes through a two-flop synchronizer. A qualification state machine then accepts a new level only after it has been stable for a programmable number of consecutive cycles. Single-cycle edge pulses are also produced for downstream event logic.

## Interface
- STABLE_CYCLES, 4: consecutive stable synchronized samples required to accept a new level; legal range 2 .. 2**CNT_WIDTH.
- CNT_WIDTH, 3: width of the qualification counter; must satisfy 2**CNT_WIDTH >= STABLE_CYCLES.
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset. It asserts immediately and is released synchronously by the caller.
- din  input  1  raw asynchronous input.
- dout  output  1  debounced, registered level; feeds the downstream flip-flop D.
- rise  output  1  one-cycle pulse, coincident with dout going 0->1.
- fall  output  1  one-cycle pulse, coincident with dout going 1->0.
- busy  output  1  high while a candidate level change is being qualified (WAIT states).

## Operation
- Synchronizer: sync1 <= din, s <= sync1. Both flops reset to 0. No logic sits between the two flops.
- States: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW; 2-bit encoding.
- IDLE_LOW:
  - s==1 -> WAIT_HIGH, count<=1.
  - Otherwise stay, count<=0.
- WAIT_HIGH:
  - s==0 -> IDLE_LOW, count<=0; this is a glitch and is discarded.
  - Else if count==STABLE_CYCLES-1 -> IDLE_HIGH, dout<=1, rise<=1.
  - Else count<=count+1.
- IDLE_HIGH / WAIT_LOW: mirror images of the two rules above with s inverted. The qualifying exit sets dout<=0 and fall<=1.
- rise and fall are registered. Each is high for exactly one cycle and is 0 in every other cycle. They are never high together.
- busy is decoded from state: 1 in WAIT_HIGH or WAIT_LOW.
- Counter:
  - Unsigned, CNT_WIDTH bits.
  - Never exceeds STABLE_CYCLES-1 and never wraps.
  - Cleared on every return to an IDLE state.
- Any bounce during a WAIT state restarts qualification from the IDLE state. Partial credit is never retained.

## Timing
- Reset values: dout=0, rise=0, fall=0, busy=0, state=IDLE_LOW, count=0, sync1=0, s=0.
- Reset is asynchronous: asserting it mid-qualification or mid-pulse forces all reset values immediately, with no clock required.
- Latency: number the first rising edge that samples the new din as edge 1.
  - s reflects the new level after edge 2.
  - WAIT is entered at edge 3.
  - dout, rise and fall update at edge STABLE_CYCLES+2, i.e. edge 6 for the default.
- Minimum accepted pulse width on din is STABLE_CYCLES cycles. Shorter pulses never reach dout.
- After reset release with din held high: dout rises STABLE_CYCLES+2 edges later, with a rise pulse. Reset does not preload the input level.
- A level change that completes qualification can be followed immediately by a WAIT in the opposite direction on the next edge. There is no dead time.

## Structure
- Shared package/include debounce_pkg holds:
  - the state encodings ST_IDLE_LOW=2'b00, ST_WAIT_HIGH=2'b01, ST_IDLE_HIGH=2'b11, ST_WAIT_LOW=2'b10;
  - the default STABLE_CYCLES and CNT_WIDTH constants.
- Sub-module sync2 (two-flop synchronizer: clock, reset, d, q) is instantiated once. The same sync2 is reused by other asynchronous inputs in the codebase.
- FSM, counter and pulse registers live in input_debouncer itself.

## Test plan
- Defaults; reset, release, din 0->1 held -> dout=1 and rise=1 at edge 6 only, busy high for edges 3-5, fall never asserts.
- din high pulse of 3 cycles -> dout stays 0, rise never asserts, busy high then drops, state back in IDLE_LOW.
- din bounce 1,0,1,1,0,1 then held 1 -> dout rises 6 edges after the final 0->1 transition, with exactly one rise pulse.
- From dout=1, din 1->0 held -> dout=0 with a one-cycle fall pulse at edge 6. A preceding 2-cycle low glitch produces no fall.
- Reset asserted asynchronously in WAIT_HIGH at count=2, between clock edges -> all outputs 0 immediately. After release with din still high, dout rises STABLE_CYCLES+2 edges later.
- STABLE_CYCLES=8, CNT_WIDTH=3; din held high -> dout at edge 10, counter peaks at 7 with no wrap.
